// File: rtl/shape_programmer_if.sv
// Descriptor handshake bundle for shape_programmer.
// master: the descriptor source (drives cmd_valid and the cmd_* fields).
// slave:  the programmer (drives cmd_ready).
//   cmd_valid/cmd_ready  valid/ready handshake
//   cmd_shape            target stage index
//   cmd_mask             bit i set = write register ID i
//   cmd_xcoord..height   values for register IDs 0..3
//   cmd_color            value for register ID 4
interface shape_programmer_if #(
  parameter int COORD_W  = 12,
  parameter int DATA_W   = 12,
  parameter int NUM_REGS = 5
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_shape;
  logic [NUM_REGS-1:0] cmd_mask;
  logic [COORD_W-1:0]  cmd_xcoord;
  logic [COORD_W-1:0]  cmd_ycoord;
  logic [COORD_W-1:0]  cmd_width;
  logic [COORD_W-1:0]  cmd_height;
  logic [DATA_W-1:0]   cmd_color;

  modport master (
    output cmd_valid, cmd_shape, cmd_mask, cmd_xcoord, cmd_ycoord,
           cmd_width, cmd_height, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_shape, cmd_mask, cmd_xcoord, cmd_ycoord,
           cmd_width, cmd_height, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/shape_programmer.sv
// Head-of-chain initiator for the renderer programming protocol.
// Latches one shape descriptor and serialises it into per-register program
// beats (program=1, x=stage index, y=register ID, data=value), injected only
// during blanking. Otherwise the pixel stream passes through, registered.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cmd              descriptor handshake (slave side)
//   blank_in         high = blanking, stream may be overwritten
//   x_in/y_in/data_in     pixel stream from scan generator
//   program_out/x_out/y_out/data_out  registered stream to first stage
//   busy             descriptor held and not fully sent
module shape_programmer #(
  parameter int COORD_W  = 12,
  parameter int DATA_W   = 12,
  parameter int NUM_REGS = 5
) (
  input  logic               clk,
  input  logic               reset,
  shape_programmer_if.slave  cmd,
  input  logic               blank_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [DATA_W-1:0]  data_in,
  output logic               program_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy
);
  localparam int ID_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;

  // rem holds the mask bits still to be sent; the pointer is its lowest set bit
  logic [NUM_REGS-1:0] rem, rem_n;
  logic [COORD_W-1:0]  shape_q, xcoord_q, ycoord_q, width_q, height_q;
  logic [DATA_W-1:0]   color_q;
  logic [ID_W-1:0]     id;
  logic [DATA_W-1:0]   field;
  logic                ready, beat, accept;

  always_comb begin
    id = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (rem[i]) id = ID_W'(i);
  end

  always_comb begin
    field = color_q;
    case (id)
      ID_W'(0): field = DATA_W'(xcoord_q);
      ID_W'(1): field = DATA_W'(ycoord_q);
      ID_W'(2): field = DATA_W'(width_q);
      ID_W'(3): field = DATA_W'(height_q);
      default:  field = color_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    ready   = 1'b0;
    beat    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) state_n = SEND;
      end
      SEND: begin
        // an empty mask still spends one SEND cycle
        if (rem == '0) state_n = IDLE;
        else if (blank_in) begin
          beat  = 1'b1;
          rem_n = rem & ~(NUM_REGS'(1) << id);
          if (rem_n == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd.cmd_ready = ready & ~reset;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign busy          = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      rem         <= '0;
      shape_q     <= '0;
      xcoord_q    <= '0;
      ycoord_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      color_q     <= '0;
    end else begin
      if (accept) begin
        rem      <= cmd.cmd_mask;
        shape_q  <= cmd.cmd_shape;
        xcoord_q <= cmd.cmd_xcoord;
        ycoord_q <= cmd.cmd_ycoord;
        width_q  <= cmd.cmd_width;
        height_q <= cmd.cmd_height;
        color_q  <= cmd.cmd_color;
      end else begin
        rem <= rem_n;
      end
      if (beat) begin
        program_out <= 1'b1;
        x_out       <= shape_q;
        y_out       <= COORD_W'(id);
        data_out    <= field;
      end else begin
        program_out <= 1'b0;
        x_out       <= x_in;
        y_out       <= y_in;
        data_out    <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_shape_programmer.sv
// Bench for shape_programmer: directed vector table, hand sequences for
// pause / mid-burst reset / handshake corners, and random traffic against a
// queue-based reference model.
module tb_shape_programmer;
  localparam int CW = 12;
  localparam int DW = 12;
  localparam int NR = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          blank_in;
  logic [CW-1:0] x_in, y_in, x_out, y_out;
  logic [DW-1:0] data_in, data_out;
  logic          program_out, busy;

  always #5 clk = ~clk;

  shape_programmer_if #(.COORD_W(CW), .DATA_W(DW), .NUM_REGS(NR)) cmd ();

  shape_programmer #(.COORD_W(CW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .blank_in(blank_in),
    .x_in(x_in), .y_in(y_in), .data_in(data_in),
    .program_out(program_out), .x_out(x_out), .y_out(y_out),
    .data_out(data_out), .busy(busy)
  );

  typedef struct {
    logic rst, valid, blank;
    logic [CW-1:0] shape;
    logic [NR-1:0] mask;
    logic [CW-1:0] xc, yc, w, h;
    logic [DW-1:0] color;
    logic [CW-1:0] xi, yi;
    logic [DW-1:0] di;
  } in_t;

  typedef struct {
    in_t         i;
    logic [38:0] e;  // {program, x, y, data, ready, busy}
  } vec_t;

  int errors = 0;
  int checks = 0;

  // reference model: pending beats as a queue of (id, value)
  bit            m_send = 0;
  int            m_ids[$];
  logic [DW-1:0] m_vals[$];
  logic [CW-1:0] m_shape = '0;
  logic [38:0]   m_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(logic rst, logic valid, logic blank, logic [CW-1:0] shape,
                               logic [NR-1:0] mask, logic [CW-1:0] xc, logic [CW-1:0] yc,
                               logic [CW-1:0] w, logic [CW-1:0] h, logic [DW-1:0] color);
    in_t r;
    r.rst = rst; r.valid = valid; r.blank = blank; r.shape = shape; r.mask = mask;
    r.xc = xc; r.yc = yc; r.w = w; r.h = h; r.color = color;
    r.xi = 12'd100; r.yi = 12'd50; r.di = 12'h0AB;
    return r;
  endfunction

  function automatic in_t idle_in(logic blank);
    return mkin(1'b0, 1'b0, blank, '0, '0, '0, '0, '0, '0, '0);
  endfunction

  function automatic logic [38:0] ex(logic p, logic [CW-1:0] x, logic [CW-1:0] y,
                                     logic [DW-1:0] d, logic r, logic b);
    return {p, x, y, d, r, b};
  endfunction

  function automatic logic [38:0] dut_out();
    return {program_out, x_out, y_out, data_out, cmd.cmd_ready, busy};
  endfunction

  task automatic drive(input in_t v);
    reset = v.rst; cmd.cmd_valid = v.valid; blank_in = v.blank;
    cmd.cmd_shape = v.shape; cmd.cmd_mask = v.mask;
    cmd.cmd_xcoord = v.xc; cmd.cmd_ycoord = v.yc; cmd.cmd_width = v.w;
    cmd.cmd_height = v.h; cmd.cmd_color = v.color;
    x_in = v.xi; y_in = v.yi; data_in = v.di;
  endtask

  task automatic model_step(input in_t v);
    logic p; logic [CW-1:0] xo, yo; logic [DW-1:0] d;
    if (v.rst) begin
      m_ids.delete(); m_vals.delete(); m_send = 0;
      p = 0; xo = '0; yo = '0; d = '0;
    end else begin
      p = 0; xo = v.xi; yo = v.yi; d = v.di;
      if (m_send) begin
        if (m_ids.size() == 0) m_send = 0;
        else if (v.blank) begin
          p = 1; xo = m_shape; yo = CW'(m_ids.pop_front()); d = m_vals.pop_front();
          if (m_ids.size() == 0) m_send = 0;
        end
      end else if (v.valid) begin
        logic [DW-1:0] f[NR];
        f[0] = v.xc; f[1] = v.yc; f[2] = v.w; f[3] = v.h; f[4] = v.color;
        m_shape = v.shape;
        for (int k = 0; k < NR; k++)
          if (v.mask[k]) begin m_ids.push_back(k); m_vals.push_back(f[k]); end
        m_send = 1;
      end
    end
    m_exp = ex(p, xo, yo, d, !m_send && !v.rst, m_send);
  endtask

  task automatic cycle(input in_t v, input string tag);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    chk(tag, 64'(dut_out()), 64'(m_exp));
  endtask

  vec_t tbl[12];
  in_t  v;
  int   ids[$];

  initial begin
    // reset, idle passthrough, full descriptor, sparse descriptor
    tbl[0].i  = mkin(1, 0, 0, '0, '0, '0, '0, '0, '0, '0);
    tbl[0].e  = ex(0, 0, 0, 0, 0, 0);
    tbl[1].i  = idle_in(0);
    tbl[1].e  = ex(0, 100, 50, 12'h0AB, 1, 0);
    tbl[2].i  = mkin(0, 1, 1, 12'd2, 5'b11111, 12'd10, 12'd20, 12'd30, 12'd40, 12'hF00);
    tbl[2].e  = ex(0, 100, 50, 12'h0AB, 0, 1);
    tbl[3].i  = idle_in(1); tbl[3].e = ex(1, 2, 0, 12'd10, 0, 1);
    tbl[4].i  = idle_in(1); tbl[4].e = ex(1, 2, 1, 12'd20, 0, 1);
    tbl[5].i  = idle_in(1); tbl[5].e = ex(1, 2, 2, 12'd30, 0, 1);
    tbl[6].i  = idle_in(1); tbl[6].e = ex(1, 2, 3, 12'd40, 0, 1);
    tbl[7].i  = idle_in(1); tbl[7].e = ex(1, 2, 4, 12'hF00, 1, 0);
    tbl[8].i  = idle_in(1); tbl[8].e = ex(0, 100, 50, 12'h0AB, 1, 0);
    tbl[9].i  = mkin(0, 1, 1, 12'd3, 5'b10010, 12'd1, 12'd22, 12'd7, 12'd9, 12'h00F);
    tbl[9].e  = ex(0, 100, 50, 12'h0AB, 0, 1);
    tbl[10].i = idle_in(1); tbl[10].e = ex(1, 3, 1, 12'd22, 0, 1);
    tbl[11].i = idle_in(1); tbl[11].e = ex(1, 3, 4, 12'h00F, 1, 0);

    for (int n = 0; n < 12; n++) begin
      cycle(tbl[n].i, $sformatf("model_vec%0d", n));
      chk($sformatf("table_vec%0d", n), 64'(dut_out()), 64'(tbl[n].e));
    end

    // blank pause: beats only in blank cycles, IDs 0..4 in order
    cycle(mkin(0, 1, 0, 12'd1, 5'b11111, 12'd5, 12'd6, 12'd7, 12'd8, 12'h123), "pause_acc");
    ids.delete();
    foreach (tbl[n]) if (n < 8) begin
      logic b;
      b = (n == 0 || n == 3 || n == 4 || n == 6 || n == 7);
      cycle(idle_in(b), $sformatf("pause%0d", n));
      if (program_out) ids.push_back(int'(y_out));
      chk($sformatf("pause_kind%0d", n), 64'(program_out), 64'(b));
    end
    chk("pause_beats", 64'(ids.size()), 64'd5);
    foreach (ids[k]) chk($sformatf("pause_id%0d", k), 64'(ids[k]), 64'(k));

    // reset after beat ID=1 aborts; new descriptor restarts at ID 0
    cycle(mkin(0, 1, 1, 12'd4, 5'b11111, 12'd11, 12'd12, 12'd13, 12'd14, 12'h0CC), "mr_acc");
    cycle(idle_in(1), "mr_b0");
    cycle(idle_in(1), "mr_b1");
    chk("mr_b1_id", 64'(y_out), 64'd1);
    cycle(mkin(1, 0, 1, '0, '0, '0, '0, '0, '0, '0), "mr_rst");
    chk("mr_rst_out", 64'(dut_out()), 64'(ex(0, 0, 0, 0, 0, 0)));
    cycle(idle_in(1), "mr_idle");
    cycle(mkin(0, 1, 1, 12'd4, 5'b11111, 12'd21, 12'd22, 12'd23, 12'd24, 12'h0DD), "mr_acc2");
    cycle(idle_in(1), "mr_first");
    chk("mr_first_beat", 64'({program_out, y_out, data_out}), 64'({1'b1, 12'd0, 12'd21}));
    for (int n = 0; n < 4; n++) cycle(idle_in(1), "mr_drain");

    // valid held with changing fields during SEND is ignored
    cycle(mkin(0, 1, 1, 12'd1, 5'b00101, 12'd31, 12'd32, 12'd33, 12'd34, 12'h0EE), "hs_acc");
    for (int n = 0; n < 2; n++) begin
      v = mkin(0, 1, 1, CW'($urandom), NR'($urandom), CW'($urandom), CW'($urandom),
               CW'($urandom), CW'($urandom), DW'($urandom));
      cycle(v, "hs_hold");
      chk("hs_ready", 64'(cmd.cmd_ready), 64'(n == 1));
    end
    cycle(idle_in(1), "hs_settle");
    for (int n = 0; n < 6; n++) cycle(idle_in(1), "hs_drain");

    // mask 0: one SEND cycle, no beats, ready returns
    cycle(mkin(0, 1, 1, 12'd1, 5'b00000, 12'd1, 12'd2, 12'd3, 12'd4, 12'h005), "m0_acc");
    cycle(idle_in(1), "m0_send");
    chk("m0_ready", 64'({program_out, cmd.cmd_ready, busy}), 64'(3'b010));

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      v = mkin(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) != 0), CW'($urandom), NR'($urandom),
               CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), DW'($urandom));
      v.xi = CW'($urandom); v.yi = CW'($urandom); v.di = DW'($urandom);
      cycle(v, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shape_programmer.md
Name: shape_programmer

Overview:
- Head-of-chain initiator for the renderer programming protocol.
- Accepts a shape descriptor over a valid/ready handshake and serialises it into per-register program beats (program=1, x=target stage index, y=register ID, data=value).
- Sits between the scan/pixel generator and the first renderer stage. Passes the pixel stream through unchanged when not programming.
- Programming beats are injected only while the display is in blanking.

Parameters:
- COORD_W, 12, width of x/y buses and of all descriptor fields.
- DATA_W, 12, width of data bus (colour/value).
- NUM_REGS, 5, registers per stage (IDs 0..4: xcoord, ycoord, width, height, color).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  block can accept descriptor
- cmd_shape  in  COORD_W  target stage index (0 = first stage after this block)
- cmd_mask  in  NUM_REGS  bit i set = write register ID i
- cmd_xcoord, cmd_ycoord, cmd_width, cmd_height  in  COORD_W each  values for IDs 0..3
- cmd_color  in  DATA_W  value for ID 4
- blank_in  in  1  high = blanking interval, pixel stream may be overwritten
- x_in, y_in  in  COORD_W  pixel coordinates from scan generator
- data_in  in  DATA_W  background pixel value
- program_out  out  1  beat is a programming beat
- x_out, y_out  out  COORD_W  pixel coords, or stage index / reg ID during programming
- data_out  out  DATA_W  pixel value, or register value
- busy  out  1  descriptor held and not fully sent

Behaviour:
- All stream outputs are registered, 1-cycle latency from inputs/state.
- Reset (synchronous, dominant over everything):
  - state=IDLE; program_out=0, x_out=0, y_out=0, data_out=0, busy=0.
  - cmd_ready=0 while reset is high.
  - Held descriptor discarded. A mid-burst reset aborts the burst. Registers already written in downstream stages keep their values (stages are not reset).
- States:
  - IDLE: cmd_ready=1, busy=0, passthrough (program_out<=0, x/y/data_out<=x/y/data_in). On cmd_valid&cmd_ready, latch all cmd_* fields and go to SEND next cycle.
  - SEND: cmd_ready=0, busy=1. Internal ID pointer starts at the lowest set mask bit.
    - Cycle with blank_in=1: emit program_out<=1, x_out<=shape, y_out<=ID, data_out<=field[ID] (colour zero-extended/truncated to DATA_W as declared). Then advance the pointer to the next set mask bit above ID.
    - Cycle with blank_in=0: emit passthrough pixel, pointer held (pause; no beat lost or duplicated).
    - After the beat for the highest set mask bit, go to IDLE. cmd_ready is high the following cycle.
  - A mask of 0 means accept, spend one SEND cycle with no beats (passthrough), then IDLE.
- Beats are emitted in ascending ID order, one per blanking cycle, never more than popcount(mask) beats per descriptor.
- Downstream stages decrement x on each programming beat; a stage writes when it sees x==0. cmd_shape=k therefore programs the k-th stage.
- No back-to-back acceptance: at most one descriptor is held. Minimum spacing is popcount(mask)+1 cycles.
- cmd_* fields may change freely when not accepted. Only the latched copy is used.
- y_out carries the ID in its low bits, upper bits zero.

Test Plan:
- Reset then idle: x_in=100, y_in=50, data_in=0x0AB, blank_in=0 -> next cycle program_out=0, x_out=100, y_out=50, data_out=0x0AB; cmd_ready=1.
- Full descriptor, blank_in=1 continuously: shape=2, mask=5'b11111, x=10, y=20, w=30, h=40, color=0xF00 -> 5 consecutive beats (x_out=2, y_out=0..4, data_out=10,20,30,40,0xF00); busy high throughout; cmd_ready high the cycle after the last beat. With a 3-stage renderer chain attached, stage 2 renders a 0xF00 rect at (10,20) size 30x40.
- Sparse mask: mask=5'b10010, w=7, color=0x00F -> exactly 2 beats: (y_out=1, data=ycoord), (y_out=4, data=0x00F).
- Blank pause: full descriptor, blank_in toggles 1,0,0,1,1,0,1,1 -> beats appear only in blank cycles; pixel passthrough in the others; IDs 0..4 in order, none duplicated.
- Reset mid-burst: assert reset after beat ID=1 -> next output program_out=0, all outputs 0, busy=0. After release, a new descriptor is accepted and sent from the beginning.
- Handshake: cmd_valid held high with changing fields during SEND -> cmd_ready=0, fields ignored. Mask=0 descriptor -> no beats, cmd_ready returns after 1 cycle.
